// File: rtl/i2c_slave_rx.sv
// I2C write-only target receiver: accepts {addr, 0} followed by two data
// bytes, ACKs each, and commits a 7-bit register address plus 9-bit data.
module i2c_slave_rx #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  output logic       reg_wr,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ACK_A     = 3'd2,
    ST_BYTE1     = 3'd3,
    ST_ACK_1     = 3'd4,
    ST_BYTE2     = 3'd5,
    ST_ACK_2     = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic scl_d_r, sda_d_r;
  logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s, in_frame_s;

  state_t state_r, state_nxt_s;
  logic [3:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0] shift_r, shift_nxt_s, byte1_r, byte1_nxt_s;
  logic sda_oe_r, sda_oe_nxt_s, busy_r, busy_nxt_s;
  logic [6:0] reg_addr_r, reg_addr_nxt_s;
  logic [8:0] reg_data_r, reg_data_nxt_s;
  logic reg_wr_r, reg_wr_nxt_s, frame_err_r, frame_err_nxt_s;
  // xtra: an SCL rise was seen after the last ACK; xerr: overrun already reported
  logic xtra_r, xtra_nxt_s, xerr_r, xerr_nxt_s;

  // Bring SCL/SDA into the clk domain and keep one extra sample for edges
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_r <= '1;
      sda_sync_r <= '1;
      scl_d_r    <= 1'b1;
      sda_d_r    <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], i2c_sclk};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], i2c_sdat};
      scl_d_r    <= scl_sync_r[SYNC_STAGES-1];
      sda_d_r    <= sda_sync_r[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_r[SYNC_STAGES-1];
  assign sda_s      = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_d_r;
  assign scl_fall_s = ~scl_s & scl_d_r;
  assign start_s    = scl_s & ~sda_s & sda_d_r;
  assign stop_s     = scl_s & sda_s & ~sda_d_r;

  // Flag states belonging to a matched but not yet committed frame
  always_comb begin
    case (state_r)
      ST_ACK_A, ST_BYTE1, ST_ACK_1, ST_BYTE2, ST_ACK_2: in_frame_s = 1'b1;
      default:                                         in_frame_s = 1'b0;
    endcase
  end

  // Next-state and output decode; STOP beats START beats SCL edges
  always_comb begin
    state_nxt_s     = state_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    shift_nxt_s     = shift_r;
    byte1_nxt_s     = byte1_r;
    sda_oe_nxt_s    = sda_oe_r;
    busy_nxt_s      = busy_r;
    reg_addr_nxt_s  = reg_addr_r;
    reg_data_nxt_s  = reg_data_r;
    reg_wr_nxt_s    = 1'b0;
    frame_err_nxt_s = 1'b0;
    xtra_nxt_s      = xtra_r;
    xerr_nxt_s      = xerr_r;
    if (stop_s) begin
      state_nxt_s     = ST_IDLE;
      sda_oe_nxt_s    = 1'b0;
      busy_nxt_s      = 1'b0;
      frame_err_nxt_s = in_frame_s;
    end else if (start_s) begin
      state_nxt_s     = ST_ADDR;
      bit_cnt_nxt_s   = 4'd0;
      shift_nxt_s     = 8'h00;
      sda_oe_nxt_s    = 1'b0;
      frame_err_nxt_s = in_frame_s;
      xtra_nxt_s      = 1'b0;
      xerr_nxt_s      = 1'b0;
    end else if (scl_rise_s) begin
      case (state_r)
        ST_ADDR, ST_BYTE1, ST_BYTE2: begin
          if (bit_cnt_r < 4'd8) begin
            shift_nxt_s   = {shift_r[6:0], sda_s};
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
          end else begin
            shift_nxt_s = shift_r;
          end
        end
        ST_WAIT_STOP: xtra_nxt_s = 1'b1;
        default:      xtra_nxt_s = xtra_r;
      endcase
    end else if (scl_fall_s) begin
      case (state_r)
        ST_ADDR: begin
          if (bit_cnt_r == 4'd8) begin
            if (shift_r == {DEV_ADDR, 1'b0}) begin
              state_nxt_s  = ST_ACK_A;
              sda_oe_nxt_s = 1'b1;
              busy_nxt_s   = 1'b1;
            end else begin
              state_nxt_s  = ST_IDLE;
              sda_oe_nxt_s = 1'b0;
              busy_nxt_s   = 1'b0;
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_BYTE1: begin
          if (bit_cnt_r == 4'd8) begin
            state_nxt_s  = ST_ACK_1;
            byte1_nxt_s  = shift_r;
            sda_oe_nxt_s = 1'b1;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_BYTE2: begin
          if (bit_cnt_r == 4'd8) begin
            state_nxt_s  = ST_ACK_2;
            sda_oe_nxt_s = 1'b1;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_ACK_A, ST_ACK_1: begin
          state_nxt_s   = (state_r == ST_ACK_A) ? ST_BYTE1 : ST_BYTE2;
          sda_oe_nxt_s  = 1'b0;
          bit_cnt_nxt_s = 4'd0;
          shift_nxt_s   = 8'h00;
        end
        ST_ACK_2: begin
          // byte2 is still in the shifter during the final ACK clock
          state_nxt_s    = ST_WAIT_STOP;
          sda_oe_nxt_s   = 1'b0;
          reg_addr_nxt_s = byte1_r[7:1];
          reg_data_nxt_s = {byte1_r[0], shift_r};
          reg_wr_nxt_s   = 1'b1;
          xtra_nxt_s     = 1'b0;
          xerr_nxt_s     = 1'b0;
        end
        ST_WAIT_STOP: begin
          // Reported on the fall after the rise: a STOP also raises SCL but
          // never lowers it again, so only a genuine extra clock reaches here.
          if (xtra_r && !xerr_r) begin
            frame_err_nxt_s = 1'b1;
            xerr_nxt_s      = 1'b1;
          end else begin
            frame_err_nxt_s = 1'b0;
          end
        end
        default: state_nxt_s = state_r;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 4'd0;
      shift_r     <= 8'h00;
      byte1_r     <= 8'h00;
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
      reg_addr_r  <= 7'h00;
      reg_data_r  <= 9'h000;
      reg_wr_r    <= 1'b0;
      frame_err_r <= 1'b0;
      xtra_r      <= 1'b0;
      xerr_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      shift_r     <= shift_nxt_s;
      byte1_r     <= byte1_nxt_s;
      sda_oe_r    <= sda_oe_nxt_s;
      busy_r      <= busy_nxt_s;
      reg_addr_r  <= reg_addr_nxt_s;
      reg_data_r  <= reg_data_nxt_s;
      reg_wr_r    <= reg_wr_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      xtra_r      <= xtra_nxt_s;
      xerr_r      <= xerr_nxt_s;
    end
  end

  assign i2c_sdat  = sda_oe_r ? 1'b0 : 1'bz;
  assign reg_addr  = reg_addr_r;
  assign reg_data  = reg_data_r;
  assign reg_wr    = reg_wr_r;
  assign busy      = busy_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Scoreboard bench for i2c_slave_rx: a bit-banged master issues directed
// frames, expected commits are queued, and a monitor checks each reg_wr.
module tb_i2c_slave_rx;

  localparam int Q = 100; // quarter SCL period; SCL period = 40 clk

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       master_sda = 1'b1;
  wire        sda_bus;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       reg_wr, busy, frame_err;

  typedef struct packed {
    logic [6:0] a;
    logic [8:0] d;
  } wr_t;

  wr_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   fe_cnt = 0;
  int   fe_base;
  logic ack;
  logic prev_dut_drv = 1'b0;

  pullup (sda_bus);
  assign sda_bus = master_sda ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_slave_rx #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .i2c_sclk(scl), .i2c_sdat(sda_bus),
    .reg_addr(reg_addr), .reg_data(reg_data), .reg_wr(reg_wr),
    .busy(busy), .frame_err(frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every commit, count frame_err pulses,
  // and flag any new low drive from the target while SCL is high
  always @(negedge clk) begin
    logic dut_drv;
    wr_t  e;
    if (reg_wr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_reg_wr", {16'h0, reg_addr, reg_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("reg_wr_addr", {25'h0, reg_addr}, {25'h0, e.a});
        check("reg_wr_data", {23'h0, reg_data}, {23'h0, e.d});
      end
    end
    if (frame_err) fe_cnt++;
    dut_drv = master_sda && (sda_bus === 1'b0);
    if (dut_drv && !prev_dut_drv && scl) check("drive_while_scl_high", 32'd1, 32'd0);
    prev_dut_drv <= dut_drv;
  end

  task automatic i2c_start();
    master_sda = 1'b1; #(Q);
    scl = 1'b1;        #(Q);
    master_sda = 1'b0; #(Q);
    scl = 1'b0;        #(Q);
  endtask

  task automatic i2c_stop();
    master_sda = 1'b0; #(Q);
    scl = 1'b1;        #(Q);
    master_sda = 1'b1; #(2*Q);
  endtask

  task automatic send_bit(input logic b);
    master_sda = b; #(Q);
    scl = 1'b1;     #(2*Q);
    scl = 1'b0;     #(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    master_sda = 1'b1; #(Q);
    scl = 1'b1;        #(Q);
    acked = (sda_bus === 1'b0);
    #(Q);
    scl = 1'b0;        #(Q);
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("rst_reg_addr", {25'h0, reg_addr}, 32'h0);
    check("rst_reg_data", {23'h0, reg_data}, 32'h0);
    check("rst_reg_wr", {31'h0, reg_wr}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_sda_released", {31'h0, sda_bus}, 32'h1);
    reset = 1'b0;
    settle();

    // Full frame: addr 0x0F, data 0x000
    fe_base = fe_cnt;
    exp_q.push_back('{a: 7'h0F, d: 9'h000});
    i2c_start();
    send_byte(8'h34, ack); check("t1_ack_addr", {31'h0, ack}, 32'h1);
    check("t1_busy_mid", {31'h0, busy}, 32'h1);
    send_byte(8'h1E, ack); check("t1_ack_b1", {31'h0, ack}, 32'h1);
    send_byte(8'h00, ack); check("t1_ack_b2", {31'h0, ack}, 32'h1);
    i2c_stop(); settle();
    check("t1_busy_end", {31'h0, busy}, 32'h0);
    check("t1_frame_err", fe_cnt - fe_base, 32'd0);
    check("t1_queue_drained", exp_q.size(), 32'd0);

    // Wrong address: NACK, no busy, no commit
    fe_base = fe_cnt;
    i2c_start();
    send_byte(8'h36, ack); check("t2_nack", {31'h0, ack}, 32'h0);
    check("t2_busy", {31'h0, busy}, 32'h0);
    i2c_stop(); settle();
    check("t2_reg_addr_kept", {25'h0, reg_addr}, 32'h0F);
    check("t2_frame_err", fe_cnt - fe_base, 32'd0);

    // Truncated frame: two ACKs, STOP aborts, nothing committed
    fe_base = fe_cnt;
    i2c_start();
    send_byte(8'h34, ack); check("t3_ack_addr", {31'h0, ack}, 32'h1);
    send_byte(8'h0C, ack); check("t3_ack_b1", {31'h0, ack}, 32'h1);
    i2c_stop(); settle();
    check("t3_frame_err", fe_cnt - fe_base, 32'd1);
    check("t3_reg_addr_kept", {25'h0, reg_addr}, 32'h0F);
    check("t3_reg_data_kept", {23'h0, reg_data}, 32'h000);
    check("t3_busy_end", {31'h0, busy}, 32'h0);

    // Over-length frame: commit, then 4th byte NACKed with one frame_err
    fe_base = fe_cnt;
    exp_q.push_back('{a: 7'h09, d: 9'h001});
    i2c_start();
    send_byte(8'h34, ack); check("t4_ack_addr", {31'h0, ack}, 32'h1);
    send_byte(8'h12, ack); check("t4_ack_b1", {31'h0, ack}, 32'h1);
    send_byte(8'h01, ack); check("t4_ack_b2", {31'h0, ack}, 32'h1);
    send_byte(8'hAA, ack); check("t4_nack_b3", {31'h0, ack}, 32'h0);
    i2c_stop(); settle();
    check("t4_frame_err", fe_cnt - fe_base, 32'd1);
    check("t4_queue_drained", exp_q.size(), 32'd0);

    // Repeated START abandons a matched partial frame, then a full frame
    fe_base = fe_cnt;
    exp_q.push_back('{a: 7'h07, d: 9'h042});
    i2c_start();
    send_byte(8'h34, ack); check("t5_ack_addr1", {31'h0, ack}, 32'h1);
    send_byte(8'h0E, ack); check("t5_ack_b1a", {31'h0, ack}, 32'h1);
    i2c_start();
    send_byte(8'h34, ack); check("t5_ack_addr2", {31'h0, ack}, 32'h1);
    send_byte(8'h0E, ack); check("t5_ack_b1b", {31'h0, ack}, 32'h1);
    send_byte(8'h42, ack); check("t5_ack_b2", {31'h0, ack}, 32'h1);
    i2c_stop(); settle();
    check("t5_frame_err", fe_cnt - fe_base, 32'd1);
    check("t5_queue_drained", exp_q.size(), 32'd0);

    // Reset in the middle of byte 2, then a clean frame commits
    i2c_start();
    send_byte(8'h34, ack); check("t6_ack_addr", {31'h0, ack}, 32'h1);
    send_byte(8'h1E, ack); check("t6_ack_b1", {31'h0, ack}, 32'h1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("t6_rst_busy", {31'h0, busy}, 32'h0);
    check("t6_rst_reg_addr", {25'h0, reg_addr}, 32'h0);
    check("t6_rst_reg_data", {23'h0, reg_data}, 32'h0);
    i2c_stop(); settle();
    fe_base = fe_cnt;
    exp_q.push_back('{a: 7'h15, d: 9'h055});
    i2c_start();
    send_byte(8'h34, ack); check("t6_ack_addr2", {31'h0, ack}, 32'h1);
    send_byte(8'h2A, ack); check("t6_ack_b1b", {31'h0, ack}, 32'h1);
    send_byte(8'h55, ack); check("t6_ack_b2", {31'h0, ack}, 32'h1);
    i2c_stop(); settle();
    check("t6_frame_err", fe_cnt - fe_base, 32'd0);
    check("t6_reg_addr", {25'h0, reg_addr}, 32'h15);
    check("t6_reg_data", {23'h0, reg_data}, 32'h055);
    check("final_queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
